// File: rtl/exe_div_unit.sv
// exe_div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU in the EXE stage
module exe_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EXE_DivStart,
  input  logic             EXE_DivSigned,
  input  logic [WIDTH-1:0] EXE_ResultA,
  input  logic [WIDTH-1:0] EXE_ResultB,
  input  logic             EXE_Flush,
  output logic             EXE_DivBusy,
  output logic             EXE_DivDone,
  output logic [WIDTH-1:0] EXE_DivLO,
  output logic [WIDTH-1:0] EXE_DivHI
);
  localparam int CNT_W = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_SIGN, S_DONE} state_t;
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic               r_qneg;
  logic               r_rneg;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic               w_accept;
  // Operand magnitudes and one restoring step; the shifted remainder is WIDTH+1 bits wide
  // but the post-subtract value is always below the divisor, so WIDTH bits suffice for it.
  always_comb begin
    w_a_neg  = EXE_DivSigned & EXE_ResultA[WIDTH-1];
    w_b_neg  = EXE_DivSigned & EXE_ResultB[WIDTH-1];
    w_a_mag  = w_a_neg ? -EXE_ResultA : EXE_ResultA;
    w_b_mag  = w_b_neg ? -EXE_ResultB : EXE_ResultB;
    w_shift  = {r_rem, r_quo[WIDTH-1]};
    w_ge     = w_shift >= {1'b0, r_divisor};
    w_sub    = w_shift[WIDTH-1:0] - r_divisor;
    w_accept = EXE_DivStart & (r_state == S_IDLE || r_state == S_DONE);
  end
  // Control FSM and datapath. A zero divisor yields an all-ones magnitude quotient and
  // |A| as remainder, so suppressing the quotient sign for B==0 gives LO=-1 and HI=A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
    end else if (EXE_Flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_DIV: begin
          r_rem   <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_quo   <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt   <= r_cnt - 1'b1;
          r_state <= (r_cnt == '0) ? S_SIGN : S_DIV;
        end
        S_SIGN: begin
          r_lo    <= r_qneg ? -r_quo : r_quo;
          r_hi    <= r_rneg ? -r_rem : r_rem;
          r_state <= S_DONE;
        end
        default: begin
          if (w_accept) begin
            r_divisor <= w_b_mag;
            r_quo     <= w_a_mag;
            r_rem     <= '0;
            r_qneg    <= (w_a_neg ^ w_b_neg) & (|EXE_ResultB);
            r_rneg    <= w_a_neg;
            r_cnt     <= CNT_W'(WIDTH - 1);
            r_state   <= S_DIV;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end
  assign EXE_DivBusy = (r_state == S_DIV) || (r_state == S_SIGN);
  assign EXE_DivDone = (r_state == S_DONE);
  assign EXE_DivLO   = r_lo;
  assign EXE_DivHI   = r_hi;
endmodule

// File: tb/tb_exe_div_unit.sv
// tb_exe_div_unit: scoreboard bench for the EXE-stage divider
module tb_exe_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] lo;
  logic [31:0] hi;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          cyc;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exe_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .EXE_DivStart(start), .EXE_DivSigned(sgn),
    .EXE_ResultA(a), .EXE_ResultB(b), .EXE_Flush(flush),
    .EXE_DivBusy(busy), .EXE_DivDone(done), .EXE_DivLO(lo), .EXE_DivHI(hi)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic push(input logic [31:0] elo, input logic [31:0] ehi);
    exp_t e;
    e.lo = elo;
    e.hi = ehi;
    e.cyc = cyc;
    q.push_back(e);
  endtask
  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("lo", lo, e.lo);
        chk("hi", hi, e.hi);
        chk("latency", cyc - e.cyc, 34);
      end
    end
  end
  // Called at a negedge; leaves the bench one negedge later with start dropped.
  task automatic issue(input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input bit exp_done, input logic [31:0] elo, input logic [31:0] ehi);
    start = 1'b1;
    sgn = s;
    a = av;
    b = bv;
    if (exp_done) push(elo, ehi);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got no done expected done within 60 cycles (cycle %0d)", cyc);
    end
  endtask
  task automatic run(input logic s, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] elo, input logic [31:0] ehi);
    issue(s, av, bv, 1'b1, elo, ehi);
    wait_done();
    @(negedge clk);
  endtask
  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_hi", hi, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'd100, 32'd7, 1'b1, 32'h0000000E, 32'h00000002);
    for (int k = 1; k <= 34; k++) begin
      chk("busy_window", {31'b0, busy}, {31'b0, k <= 33});
      chk("done_window", {31'b0, done}, {31'b0, k == 34});
      if (k < 34) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("held_lo", lo, 32'h0000000E);
    chk("held_hi", hi, 32'h00000002);
    chk("held_done", {31'b0, done}, 32'd0);
    run(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    run(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
    run(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
    run(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'h0000000F);
    run(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    run(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678);
    run(1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678);
    run(1'b1, 32'h87654321, 32'd0, 32'hFFFFFFFF, 32'h87654321);
    issue(1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_lo", lo, 32'hFFFFFFFF);
    chk("flush_hi", hi, 32'h87654321);
    run(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);
    start = 1'b1;
    flush = 1'b1;
    a = 32'd55;
    b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_start_done", {31'b0, done}, 32'd0);
    chk("flush_start_lo", lo, 32'd333);
    issue(1'b0, 32'd50000, 32'd7, 1'b1, 32'd7142, 32'd6);
    repeat (4) @(negedge clk);
    start = 1'b1;
    sgn = 1'b1;
    a = 32'hFF;
    b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
    start = 1'b1;
    sgn = 1'b0;
    a = 32'd1000;
    b = 32'd10;
    push(32'd100, 32'd0);
    wait_done();
    a = 32'hFFFFFFFF;
    b = 32'd3;
    push(32'h55555555, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    wait_done();
    @(negedge clk);
    issue(1'b0, 32'd1234, 32'd5, 1'b0, 32'd0, 32'd0);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_hi", hi, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
    repeat (3) @(negedge clk);
    chk("pending", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exe_div_unit.md
Name: exe_div_unit

Overview:
- Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EXE stage.
- It runs beside the ALU and consumes the same forwarded operand buses (EXE_ResultA = dividend, EXE_ResultB = divisor).
- Its quotient/remainder go to the HI/LO write path, and its busy flag stalls the pipeline while an operation is in flight.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
EXE_DivStart  input  1  request a division; sampled only when accepting (IDLE or DONE)
EXE_DivSigned  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
EXE_ResultA  input  WIDTH  dividend; sampled with start
EXE_ResultB  input  WIDTH  divisor; sampled with start
EXE_Flush  input  1  pipeline flush (exception/eret); cancels any operation
EXE_DivBusy  output  1  high while an accepted operation is in progress
EXE_DivDone  output  1  one-cycle pulse: EXE_DivHI/EXE_DivLO valid
EXE_DivLO  output  WIDTH  quotient, held from done until next accepted start
EXE_DivHI  output  WIDTH  remainder, held from done until next accepted start

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, EXE_DivBusy=0, EXE_DivDone=0, EXE_DivLO=0, EXE_DivHI=0, all internal registers 0.
- States: IDLE, DIV, SIGN, DONE.
- EXE_DivBusy = (state==DIV || state==SIGN); EXE_DivDone = (state==DONE). Both are decoded from registered state only, with no combinational path from inputs.
- Accept: in IDLE or DONE with EXE_DivStart=1 and EXE_Flush=0:
  - latch signedness, original dividend, and magnitude operands (|A|, |B| when signed, raw values when unsigned);
  - record quotient sign (A[31]^B[31]) and remainder sign (A[31]), both forced 0 when unsigned;
  - clear the partial remainder, set counter=WIDTH-1, go to DIV.
- DIV: each edge shifts {rem,quo} left one bit, trial-subtracts |B| from the WIDTH+1-bit partial remainder, restores if negative, and sets the quotient LSB when not negative. The counter decrements; at counter==0 the last iteration completes and the state goes to SIGN. This is exactly WIDTH iterations.
- SIGN: quotient negated if quotient sign is set; remainder negated if remainder sign is set. EXE_DivLO/EXE_DivHI are registered, and the state goes to DONE.
- DONE: lasts one cycle, then IDLE. A start in DONE is accepted, giving back-to-back operations.
- Latency: start sampled at edge 0 → EXE_DivDone high during the cycle after edge WIDTH+1 (cycle 34 for WIDTH=32). EXE_DivBusy is high for cycles 1..33.
- Start while busy: ignored, with no effect on the operation in flight. The pipeline must not issue it, because it is stalled by busy.
- Flush: synchronous. Any state → IDLE on the next edge, and no done pulse follows. Flush beats start in the same cycle. EXE_DivLO/EXE_DivHI keep their previous values.
- Divide by zero (B==0, either signedness):
  - LO=all-ones, HI=original dividend EXE_ResultA;
  - latency is the same (the iterations still run);
  - no exception is raised.
- Signed overflow (0x80000000 / 0xFFFFFFFF, signed): LO=0x80000000, HI=0, with no exception. This falls out naturally from magnitude division plus negation.
- Signs: the quotient truncates toward zero and the remainder takes the dividend's sign, per MIPS DIV.
- Outputs change only at the SIGN→DONE edge (or on reset). They are never X after reset.

Test Plan:
- Unsigned 100/7: start DIVU with A=100, B=7.
  - EXE_DivBusy=1 for cycles 1..33.
  - EXE_DivDone pulses in cycle 34 only, with LO=0x0000000E, HI=0x00000002.
  - Outputs are still held 5 cycles later.
- Signed signs, all with DIV:
  - A=0xFFFFFFF9(-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A=7, B=0xFFFFFFFE → LO=0xFFFFFFFD, HI=1.
  - A=-7, B=-2 → LO=3, HI=0xFFFFFFFF.
- Corners:
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU with the same operands → LO=0, HI=0x80000000.
  - DIVU 0x12345678/0 → LO=0xFFFFFFFF, HI=0x12345678.
  - DIV 0x12345678/0 → LO=0xFFFFFFFF, HI=0x12345678, done still in cycle 34.
- Flush mid-op:
  - Start, then EXE_Flush=1 in cycle 10 → busy=0 from cycle 11, no done pulse ever, outputs unchanged.
  - A new start in cycle 11 completes normally, with done in cycle 11+34.
  - Flush and start in the same IDLE cycle → start is not accepted.
- Back-to-back and ignored start:
  - Start held high continuously with new operands: the second op is accepted in the DONE cycle and its done arrives 34 cycles later.
  - Starts pulsed during busy have no effect on the results.
- Async reset mid-op: assert rst asynchronously at cycle 20, between edges → all outputs 0 immediately. After release, IDLE accepts a fresh start, and 9/3 DIVU gives LO=3, HI=0 at cycle 34.
